// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with per-slot anode dead time,
// leading-zero blanking and frame-synchronous (tear-free) display updates.
module display_scan_ctrl #(
    parameter int CLK_DIV  = 50000,
    parameter int DEAD_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [15:0] disp_bcd,
    output logic [1:0]  sel,
    output logic [3:0]  an_n,
    output logic        frame_done,
    output logic        load_ack
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] slot_cnt, slot_nx;
    logic [1:0]    sel_nx;
    logic [15:0]   disp_nx, shadow, shadow_nx;
    logic          pending, pend_nx;
    logic          fd_nx, ack_nx, wrap, apply;
    logic [3:0]    blank, an_nx;

    always_comb begin
        state_nx  = state;
        slot_nx   = slot_cnt;
        sel_nx    = sel;
        disp_nx   = disp_bcd;
        shadow_nx = shadow;
        pend_nx   = pending;
        fd_nx     = 1'b0;
        ack_nx    = 1'b0;

        wrap  = (state == SCAN) && enable && (slot_cnt == CW'(CLK_DIV - 1)) && (sel == 2'd3);
        // disp_bcd may only change while idle or exactly at a frame boundary
        apply = (state == IDLE) || wrap;

        case (state)
            IDLE: begin
                slot_nx = '0;
                sel_nx  = '0;
                if (enable) state_nx = SCAN;
            end
            SCAN: begin
                if (!enable) begin
                    state_nx = IDLE;
                    slot_nx  = '0;
                    sel_nx   = '0;
                end else if (slot_cnt == CW'(CLK_DIV - 1)) begin
                    slot_nx = '0;
                    sel_nx  = sel + 2'd1;
                    fd_nx   = wrap;
                end else begin
                    slot_nx = slot_cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        if (apply) begin
            if (load) begin
                disp_nx = bcd_in;
                pend_nx = 1'b0;
                ack_nx  = 1'b1;
            end else if (pending) begin
                disp_nx = shadow;
                pend_nx = 1'b0;
                ack_nx  = 1'b1;
            end
        end else if (load) begin
            shadow_nx = bcd_in;
            pend_nx   = 1'b1;
        end

        blank[0] = 1'b0;
        blank[3] = blank_lz && (disp_nx[15:12] == 4'd0);
        blank[2] = blank[3] && (disp_nx[11:8] == 4'd0);
        blank[1] = blank[2] && (disp_nx[7:4] == 4'd0);

        if ((state_nx == SCAN) && (slot_nx >= CW'(DEAD_CYC)) && !blank[sel_nx])
            an_nx = ~(4'b0001 << sel_nx);
        else
            an_nx = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot_cnt   <= '0;
            sel        <= '0;
            an_n       <= '1;
            disp_bcd   <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            state      <= state_nx;
            slot_cnt   <= slot_nx;
            sel        <= sel_nx;
            an_n       <= an_nx;
            disp_bcd   <= disp_nx;
            shadow     <= shadow_nx;
            pending    <= pend_nx;
            frame_done <= fd_nx;
            load_ack   <= ack_nx;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (CLK_DIV=8, DEAD_CYC=2): stimulus pushes
// hand-derived per-cycle expectations tagged with a cycle number; a monitor checks them.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] disp_bcd;
    logic [1:0]  sel;
    logic [3:0]  an_n;
    logic        frame_done;
    logic        load_ack;

    display_scan_ctrl #(.CLK_DIV(8), .DEAD_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bcd_in(bcd_in), .load(load),
        .blank_lz(blank_lz), .disp_bcd(disp_bcd), .sel(sel), .an_n(an_n),
        .frame_done(frame_done), .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  sel;
        logic [3:0]  an;
        logic [15:0] disp;
        logic        fd;
        logic        ack;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Entry c of a slot sequence: sel=c/8, anodes dark for slots 0..1 or when the digit is unlit.
    task automatic push_frame(input int unsigned base, input int n, input logic fd0,
                              input logic ack0, input logic [15:0] d, input logic [3:0] lit);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            e.cyc  = base + c;
            e.sel  = 2'(c / 8);
            e.an   = ((c % 8) < 2 || !lit[e.sel]) ? 4'b1111 : ~(4'b0001 << e.sel);
            e.disp = d;
            e.fd   = (c == 0) ? fd0 : 1'b0;
            e.ack  = (c == 0) ? ack0 : 1'b0;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_entry cyc=%0d actual=none required=%0d", cyc, q[0].cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("sel", 16'(sel), 16'(e.sel));
            chk("an_n", 16'(an_n), 16'(e.an));
            chk("disp_bcd", disp_bcd, e.disp);
            chk("frame_done", 16'(frame_done), 16'(e.fd));
            chk("load_ack", 16'(load_ack), 16'(e.ack));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int unsigned e);
        while (cyc < e) step(1);
    endtask

    // Assert load so that the edge numbered e samples it.
    task automatic pulse_load(input int unsigned e, input logic [15:0] v);
        goto(e - 1);
        load   = 1'b1;
        bcd_in = v;
        step(1);
        load   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an_n"}, 16'(an_n), 16'h000f);
        chk({tag, "_sel"}, 16'(sel), 16'h0000);
        chk({tag, "_disp"}, disp_bcd, 16'h0000);
        chk({tag, "_fd"}, 16'(frame_done), 16'h0000);
        chk({tag, "_ack"}, 16'(load_ack), 16'h0000);
    endtask

    initial begin
        int unsigned b, f1, f2, f3, f4, f5, f6, b2, f7;
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        step(2);
        rst_n = 1'b1;
        step(1);

        b = cyc;
        push_frame(b + 1, 1, 1'b0, 1'b1, 16'h1234, 4'b0000);
        pulse_load(b + 1, 16'h1234);

        b = cyc;
        enable = 1'b1;
        f1 = b + 1; f2 = f1 + 32; f3 = f2 + 32; f4 = f3 + 32; f5 = f4 + 32; f6 = f5 + 32;
        push_frame(f1, 32, 1'b0, 1'b0, 16'h1234, 4'b1111);
        pulse_load(f1 + 11, 16'habcd);
        push_frame(f2, 32, 1'b1, 1'b1, 16'habcd, 4'b1111);
        pulse_load(f2 + 3, 16'h1111);
        pulse_load(f2 + 20, 16'h2222);
        push_frame(f3, 32, 1'b1, 1'b1, 16'h2222, 4'b1111);
        pulse_load(f3 + 5, 16'h0045);
        goto(f4 - 1);
        blank_lz = 1'b1;
        push_frame(f4, 32, 1'b1, 1'b1, 16'h0045, 4'b0011);
        pulse_load(f5, 16'h0000);
        push_frame(f5, 32, 1'b1, 1'b1, 16'h0000, 4'b0001);
        goto(f6 - 1);
        blank_lz = 1'b0;
        push_frame(f6, 21, 1'b1, 1'b0, 16'h0000, 4'b1111);
        pulse_load(f6 + 10, 16'h5678);
        goto(f6 + 20);
        enable = 1'b0;
        push_frame(f6 + 21, 1, 1'b0, 1'b0, 16'h0000, 4'b0000);
        push_frame(f6 + 22, 2, 1'b0, 1'b1, 16'h5678, 4'b0000);
        goto(f6 + 24);

        b2 = cyc;
        enable = 1'b1;
        f7 = b2 + 33;
        push_frame(b2 + 1, 32, 1'b0, 1'b0, 16'h5678, 4'b1111);
        push_frame(f7, 12, 1'b1, 1'b0, 16'h5678, 4'b1111);
        pulse_load(f7 + 5, 16'h9999);
        goto(f7 + 12);
        #1 rst_n = 1'b0;
        enable = 1'b0;
        #1 chk_reset_outputs("midreset");
        #1 rst_n = 1'b1;
        push_frame(cyc + 1, 4, 1'b0, 1'b0, 16'h0000, 4'b0000);
        goto(cyc + 5);

        for (int i = 0; i < 10 && q.size() > 0; i++) step(1);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000, giving clock cycles per digit slot (integer, ≥ 4).
REQ-002 The block SHALL have parameter DEAD_CYC, default 16, giving anode-off cycles at the start of each slot (integer, 1 ≤ DEAD_CYC < CLK_DIV).
REQ-003 Port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port enable, input, 1 bit: 1 means scan the display, 0 means idle with all anodes off.
REQ-006 Port bcd_in, input, 16 bits: four BCD digits, digit k in bits [4k+3:4k].
REQ-007 Port load, input, 1 bit: one-cycle strobe that captures bcd_in.
REQ-008 Port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-009 Port disp_bcd, output, 16 bits: registered display value, drives the digit mux data input.
REQ-010 Port sel, output, 2 bits: registered digit index, drives the digit mux select.
REQ-011 Port an_n, output, 4 bits: registered active-low anode enables, bit k for digit k.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse at the end of digit-3 slot.
REQ-013 Port load_ack, output, 1 bit: one-cycle pulse when a captured value is written to disp_bcd.

Function
REQ-014 The state machine SHALL have two states: IDLE and SCAN; a slot counter slot_cnt runs 0..CLK_DIV-1 in SCAN.
REQ-015 In IDLE the block SHALL hold an_n=4'b1111, sel=0 and slot_cnt=0.
REQ-016 On the first edge with enable=1 in IDLE the block SHALL enter SCAN with sel=0 and slot_cnt=0.
REQ-017 In SCAN with slot_cnt < DEAD_CYC (dead time) the block SHALL drive an_n=4'b1111 while sel already shows the current digit.
REQ-018 In SCAN with slot_cnt ≥ DEAD_CYC the block SHALL drive an_n bit sel low and all other bits high, unless digit sel is blanked.
REQ-019 When slot_cnt=CLK_DIV-1 the next edge SHALL set slot_cnt=0 and sel=(sel+1) mod 4.
REQ-020 frame_done SHALL pulse for one cycle on the edge where sel wraps 3→0.
REQ-021 Blanking rule: with blank_lz=1, digit k (k=3,2,1) is blanked iff nibbles k..3 of disp_bcd are all 0; digit 0 is never blanked; with blank_lz=0 no digit is blanked.
REQ-022 Load in SCAN: load=1 SHALL copy bcd_in into a shadow register and set pending=1; a later load before application SHALL overwrite the shadow (last wins).
REQ-023 At the frame_done edge with pending=1 the block SHALL copy shadow into disp_bcd, clear pending and pulse load_ack in the same cycle as frame_done.
REQ-024 When load=1 coincides with the frame_done edge, bcd_in SHALL go directly to disp_bcd, pending SHALL clear, and load_ack SHALL pulse.
REQ-025 Load in IDLE: load=1 SHALL write bcd_in to disp_bcd on the next edge and pulse load_ack there; pending SHALL clear.
REQ-026 enable=0 during SCAN SHALL return the block to IDLE on the next edge (an_n=1111, sel=0, slot_cnt=0, no frame_done), with shadow and pending preserved.
REQ-027 A value left pending on entry to IDLE SHALL be applied on the first IDLE edge, with a load_ack pulse.
REQ-028 disp_bcd SHALL change only at the points defined in REQ-023 to REQ-025 and REQ-027, so that no frame is torn.

Reset
REQ-029 While rst_n=0, asynchronously: state=IDLE, slot_cnt=0, sel=0, an_n=4'b1111, disp_bcd=0, shadow=0, pending=0, frame_done=0, load_ack=0.
REQ-030 After rst_n rises, operation SHALL resume from IDLE on the first rising clock edge; a reset mid-slot SHALL discard the slot and any pending load.

Verification (CLK_DIV=8, DEAD_CYC=2)
REQ-031 Reset, then load bcd_in=0x1234 with enable=0 -> load_ack next cycle, disp_bcd=0x1234; then enable=1 -> sel 0,1,2,3 for 8 cycles each, an_n=1111 for 2 cycles then 1110/1101/1011/0111 for 6 cycles, frame_done at cycle 32.
REQ-032 disp_bcd=0x0045 with blank_lz=1 -> an_n stays 1111 during the digit-3 and digit-2 slots; disp_bcd=0x0000 -> only digit 0 lights; blank_lz=0 -> all four digits light.
REQ-033 Load 0xABCD at cycle 10 of a frame -> disp_bcd unchanged until the frame_done edge, load_ack coincident with frame_done; loads 0x1111 then 0x2222 in one frame -> disp_bcd=0x2222 with a single load_ack.
REQ-034 enable dropped during digit-2 drive -> an_n=1111 and sel=0 on the next edge, no frame_done; re-enable -> restart at digit 0 with dead time.
REQ-035 rst_n pulsed low mid-drive with a pending load -> an_n=1111, disp_bcd=0 immediately without a clock edge; no load_ack after release.
